// File: rtl/step_sequencer.sv
// Sequential front end of the control unit: instruction register, micro-step
// counter, latched ALU flags and RUN/HALTED state, with optional single-step gating.
module step_sequencer #(
    parameter int INSTRUCTION_WIDTH = 4,
    parameter int INSTRUCTION_STEPS = 8,
    parameter int BUS_WIDTH         = 8,
    localparam int STEP_WIDTH       = $clog2(INSTRUCTION_STEPS),
    localparam int OPERAND_WIDTH    = BUS_WIDTH - INSTRUCTION_WIDTH
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic [BUS_WIDTH-1:0]         i_bus,
    input  logic                         i_ii,
    input  logic                         i_adv,
    input  logic                         i_hlt,
    input  logic                         i_el,
    input  logic                         i_alu_zero,
    input  logic                         i_alu_carry,
    input  logic                         i_alu_odd,
    input  logic                         i_step_mode,
    input  logic                         i_step_req,
    output logic [INSTRUCTION_WIDTH-1:0] o_instruction,
    output logic [OPERAND_WIDTH-1:0]     o_operand,
    output logic [STEP_WIDTH-1:0]        o_step,
    output logic                         o_zero,
    output logic                         o_carry,
    output logic                         o_odd,
    output logic                         o_cycle_en,
    output logic                         o_halted,
    output logic                         o_step_fault
);

    localparam logic STATE_RUN    = 1'b0;
    localparam logic STATE_HALTED = 1'b1;
    localparam logic [STEP_WIDTH-1:0] LAST_STEP = STEP_WIDTH'(INSTRUCTION_STEPS - 1);

    logic                  state_reg;
    logic [BUS_WIDTH-1:0]  ir_reg;
    logic [STEP_WIDTH-1:0] step_reg;
    logic [2:0]            flag_reg;
    logic [2:0]            alu_flags;
    logic                  fault_reg;
    logic                  req_prev_reg;
    logic                  req_rise;
    logic                  cycle_en;

    // Single-step mode commits only on the first clock after a 0->1 of i_step_req.
    assign req_rise  = i_step_req & ~req_prev_reg;
    assign cycle_en  = i_reset_n & (state_reg == STATE_RUN) & (i_step_mode ? req_rise : 1'b1);
    assign alu_flags = {i_alu_zero, i_alu_carry, i_alu_odd};

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            req_prev_reg <= 1'b0;
        end else begin
            req_prev_reg <= i_step_req;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            ir_reg <= '0;
        end else if (cycle_en && i_ii) begin
            ir_reg <= i_bus;
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_flag
            always_ff @(posedge i_clk or negedge i_reset_n) begin
                if (!i_reset_n) begin
                    flag_reg[gi] <= 1'b0;
                end else if (cycle_en && i_el) begin
                    flag_reg[gi] <= alu_flags[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= STATE_RUN;
            step_reg  <= '0;
            fault_reg <= 1'b0;
        end else if (cycle_en) begin
            // Halt freezes the step counter so the halting step stays visible.
            if (i_hlt) begin
                state_reg <= STATE_HALTED;
            end else if (i_adv) begin
                step_reg <= '0;
            end else if (step_reg == LAST_STEP) begin
                step_reg  <= '0;
                fault_reg <= 1'b1;
            end else begin
                step_reg <= step_reg + 1'b1;
            end
        end
    end

    assign o_instruction = ir_reg[BUS_WIDTH-1 -: INSTRUCTION_WIDTH];
    assign o_operand     = ir_reg[OPERAND_WIDTH-1:0];
    assign o_step        = step_reg;
    assign o_zero        = flag_reg[2];
    assign o_carry       = flag_reg[1];
    assign o_odd         = flag_reg[0];
    assign o_cycle_en    = cycle_en;
    assign o_halted      = (state_reg == STATE_HALTED);
    assign o_step_fault  = fault_reg;

endmodule

// File: tb/tb_step_sequencer.sv
// Scoreboard bench for step_sequencer: directed scenarios followed by random
// stimulus, each cycle's expected outputs queued by the driver and checked by a monitor.
module tb_step_sequencer;

    localparam int STEPS = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] bus = '0;
    logic       ii = 1'b0, adv = 1'b0, hlt = 1'b0, el = 1'b0;
    logic       alu_zero = 1'b0, alu_carry = 1'b0, alu_odd = 1'b0;
    logic       step_mode = 1'b0, step_req = 1'b0;
    logic [3:0] instruction, operand;
    logic [2:0] step;
    logic       zero, carry, odd, cycle_en, halted, step_fault;

    step_sequencer #(
        .INSTRUCTION_WIDTH(4),
        .INSTRUCTION_STEPS(STEPS),
        .BUS_WIDTH(8)
    ) dut (
        .i_clk(clk),
        .i_reset_n(rst_n),
        .i_bus(bus),
        .i_ii(ii),
        .i_adv(adv),
        .i_hlt(hlt),
        .i_el(el),
        .i_alu_zero(alu_zero),
        .i_alu_carry(alu_carry),
        .i_alu_odd(alu_odd),
        .i_step_mode(step_mode),
        .i_step_req(step_req),
        .o_instruction(instruction),
        .o_operand(operand),
        .o_step(step),
        .o_zero(zero),
        .o_carry(carry),
        .o_odd(odd),
        .o_cycle_en(cycle_en),
        .o_halted(halted),
        .o_step_fault(step_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         instr;
        int         operand;
        int         step;
        int         flags;
        bit         en;
        bit         halted;
        bit         fault;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_txn = 0;

    // Reference model: machine state as plain integers.
    int   m_ir = 0;
    int   m_step = 0;
    int   m_flags = 0;
    bit   m_halted = 0;
    bit   m_fault = 0;
    bit   m_req_prev = 0;
    int   halted_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL txn %0d %s: got %0h expected %0h", n_txn, name, act, expv);
        end
    endtask

    // One cycle: apply inputs after the edge, queue what the outputs must show
    // until the next edge, then advance the model across that edge.
    task automatic drive(input bit rst, input bit mode, input bit req, input bit i_ii,
                         input bit [7:0] i_bus, input bit i_adv, input bit i_hlt,
                         input bit i_el, input bit [2:0] alu);
        exp_t e;
        bit   en;
        @(posedge clk);
        #1;
        rst_n = rst; step_mode = mode; step_req = req; ii = i_ii; bus = i_bus;
        adv = i_adv; hlt = i_hlt; el = i_el;
        {alu_zero, alu_carry, alu_odd} = alu;
        if (!rst) begin
            m_ir = 0; m_step = 0; m_flags = 0; m_halted = 0; m_fault = 0; m_req_prev = 0;
        end
        en = rst && !m_halted && (mode ? (req && !m_req_prev) : 1'b1);
        e.instr = m_ir / 16;
        e.operand = m_ir % 16;
        e.step = m_step;
        e.flags = m_flags;
        e.en = en;
        e.halted = m_halted;
        e.fault = m_fault;
        exp_q.push_back(e);
        if (rst) begin
            m_req_prev = req;
            if (en) begin
                if (i_ii) m_ir = int'(i_bus);
                if (i_el) m_flags = int'(alu);
                if (i_hlt) begin
                    m_halted = 1;
                end else if (i_adv) begin
                    m_step = 0;
                end else begin
                    if (m_step + 1 == STEPS) m_fault = 1;
                    m_step = (m_step + 1) % STEPS;
                end
            end
        end
        halted_cycles = m_halted ? halted_cycles + 1 : 0;
    endtask

    task automatic idle(input int n, input bit mode, input bit req);
        for (int k = 0; k < n; k++) drive(1, mode, req, 0, 8'h00, 0, 0, 0, 3'b000);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_txn++;
            $display("txn %0d: step=%0d ir=%h%h flags=%b en=%b halted=%b fault=%b",
                     n_txn, step, instruction, operand, {zero, carry, odd},
                     cycle_en, halted, step_fault);
            check("instruction", 32'(instruction), 32'(e.instr));
            check("operand", 32'(operand), 32'(e.operand));
            check("step", 32'(step), 32'(e.step));
            check("flags", 32'({zero, carry, odd}), 32'(e.flags));
            check("cycle_en", 32'(cycle_en), 32'(e.en));
            check("halted", 32'(halted), 32'(e.halted));
            check("step_fault", 32'(step_fault), 32'(e.fault));
        end
    end

    initial begin
        bit mode_r, req_r, rst_r;
        // Reset held from time zero.
        drive(0, 0, 0, 0, 8'h00, 0, 0, 0, 3'b000);
        drive(0, 0, 0, 0, 8'h00, 0, 0, 0, 3'b000);

        // Run mode 5-step instruction with fetch at step 1.
        drive(1, 0, 0, 0, 8'h00, 0, 0, 0, 3'b000);
        drive(1, 0, 0, 1, 8'h2A, 0, 0, 0, 3'b000);
        idle(2, 0, 0);
        // Step 4: adv with a flag latch.
        drive(1, 0, 0, 0, 8'h00, 1, 0, 1, 3'b101);
        // ALU inputs change without el: flags hold.
        drive(1, 0, 0, 0, 8'h00, 0, 0, 0, 3'b010);
        drive(1, 0, 0, 0, 8'h00, 0, 0, 0, 3'b111);

        // Overrun: no adv for a full wrap, then adv keeps the fault.
        idle(10, 0, 0);
        drive(1, 0, 0, 0, 8'h00, 1, 0, 0, 3'b000);
        idle(2, 0, 0);

        // Halt at step 2; later ii must be ignored.
        drive(1, 0, 0, 0, 8'h00, 1, 0, 0, 3'b000);
        idle(2, 0, 0);
        drive(1, 0, 0, 0, 8'h00, 0, 1, 0, 3'b000);
        for (int k = 0; k < 5; k++) drive(1, 0, 0, 1, 8'hFF, 0, 0, 1, 3'b111);
        drive(0, 0, 0, 0, 8'h00, 0, 0, 0, 3'b000);
        idle(2, 0, 0);

        // Single-step: held low, then three 4-clock pulses.
        idle(10, 1, 0);
        for (int p = 0; p < 3; p++) begin
            idle(4, 1, 1);
            idle(4, 1, 0);
        end
        // Entering the mode with the request already high.
        idle(2, 0, 1);
        idle(5, 1, 1);
        idle(2, 1, 0);
        idle(1, 0, 0);

        // Async reset at step 3 with flags set.
        drive(1, 0, 0, 0, 8'h00, 1, 0, 1, 3'b111);
        idle(3, 0, 0);
        drive(0, 0, 0, 0, 8'h00, 0, 0, 0, 3'b000);
        idle(2, 0, 0);

        // Random traffic.
        mode_r = 0; req_r = 0;
        for (int k = 0; k < 1200; k++) begin
            if ($urandom_range(0, 49) == 0) mode_r = ~mode_r;
            if ($urandom_range(0, 2) == 0) req_r = ~req_r;
            rst_r = !((m_halted && halted_cycles > 4) || $urandom_range(0, 199) == 0);
            drive(rst_r, mode_r, req_r,
                  $urandom_range(0, 2) == 0, 8'($urandom),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 39) == 0,
                  $urandom_range(0, 2) == 0, 3'($urandom));
        end

        @(negedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
